tft_text_renderer: RTL and testbench

//  Text-mode pixel stage between the TFT timing generator and the panel pins.
//  - Takes per-pixel timing (syncs, DE, active-area x/y) and fetches the character byte from text memory (port A).
//  - Looks the byte up in an 8x16 font ROM and drives the panel r/g/b, with syncs/DE delayed to match.
//  - Adds a blinking block cursor, blink period counted in frames.

---
 rtl/tft_text_renderer.sv | 156 +++++++++++++++
 tb/tb_tft_text_renderer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tft_text_renderer.sv
// Text-mode pixel stage: timing in, character fetch, font lookup, colour out.
// Three px_en-qualified stages; syncs/DE travel alongside the colour path.
module tft_text_renderer #(
    parameter int unsigned MEM_SIZE     = 8192,
    parameter int unsigned COLS         = 100,
    parameter int unsigned ROWS         = 30,
    parameter logic [23:0] FG_RGB       = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB       = 24'h000000,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        px_en,
    input  logic                        hsync_i,
    input  logic                        vsync_i,
    input  logic                        de_i,
    input  logic [9:0]                  x_i,
    input  logic [9:0]                  y_i,
    output logic [$clog2(MEM_SIZE)-1:0] text_addr,
    input  logic [31:0]                 text_data,
    output logic [11:0]                 font_addr,
    input  logic [7:0]                  font_data,
    input  logic                        cursor_en,
    input  logic [6:0]                  cursor_col,
    input  logic [4:0]                  cursor_row,
    output logic [7:0]                  r,
    output logic [7:0]                  g,
    output logic [7:0]                  b,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        de
);

    localparam int unsigned AW = $clog2(MEM_SIZE);
    localparam int unsigned CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Stage 1: sampled timing
    logic       s1_hsync, s1_vsync, s1_de;
    logic [9:0] s1_x, s1_y;

    // Stage 2: character byte and per-pixel context
    logic [7:0] s2_char;
    logic [3:0] s2_yrow;
    logic [2:0] s2_xbit;
    logic       s2_hsync, s2_vsync, s2_de, s2_oor, s2_cursor;

    logic [CW-1:0] blink_cnt;
    logic          blink_on;

    logic [6:0]  col;
    logic [5:0]  row;
    logic        oor;
    logic        cursor_hit;
    logic [7:0]  text_byte;
    logic        pixel_bit;
    logic [23:0] fg, bg, rgb_d;
    logic        vs_fall;

    assign col = s1_x[9:3];
    assign row = s1_y[9:4];

    always_comb begin
        oor        = (32'(col) >= COLS) || (32'(row) >= ROWS);
        text_addr  = oor ? '0 : AW'(row) * AW'(COLS) + AW'(col);
        cursor_hit = cursor_en && (col == cursor_col) && (row == {1'b0, cursor_row});
        text_byte  = text_data[8*text_addr[1:0] +: 8];
    end

    assign font_addr = {s2_char, s2_yrow};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_hsync <= 1'b1;
            s1_vsync <= 1'b1;
            s1_de    <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else if (px_en) begin
            s1_hsync <= hsync_i;
            s1_vsync <= vsync_i;
            s1_de    <= de_i;
            s1_x     <= x_i;
            s1_y     <= y_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_char   <= '0;
            s2_yrow   <= '0;
            s2_xbit   <= '0;
            s2_hsync  <= 1'b1;
            s2_vsync  <= 1'b1;
            s2_de     <= 1'b0;
            s2_oor    <= 1'b0;
            s2_cursor <= 1'b0;
        end else if (px_en) begin
            s2_char   <= text_byte;
            s2_yrow   <= s1_y[3:0];
            s2_xbit   <= s1_x[2:0];
            s2_hsync  <= s1_hsync;
            s2_vsync  <= s1_vsync;
            s2_de     <= s1_de;
            s2_oor    <= oor;
            s2_cursor <= cursor_hit;
        end
    end

    // Edge detect compares the new sample with the one already held in stage 1.
    assign vs_fall = s1_vsync & ~vsync_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_on  <= 1'b0;
        end else if (px_en && vs_fall) begin
            if (blink_cnt == CW'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Uses the pre-update blink_on, so an edge and a cursor pixel in one strobe see the old phase.
    always_comb begin
        pixel_bit = font_data[3'd7 - s2_xbit];
        fg        = (s2_cursor && blink_on) ? BG_RGB : FG_RGB;
        bg        = (s2_cursor && blink_on) ? FG_RGB : BG_RGB;
        if (!s2_de) begin
            rgb_d = 24'h0;
        end else if (s2_oor) begin
            rgb_d = BG_RGB;
        end else begin
            rgb_d = pixel_bit ? fg : bg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r     <= '0;
            g     <= '0;
            b     <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
            de    <= 1'b0;
        end else if (px_en) begin
            {r, g, b} <= rgb_d;
            hsync     <= s2_hsync;
            vsync     <= s2_vsync;
            de        <= s2_de;
        end
    end

endmodule

// File: tb/tb_tft_text_renderer.sv
// Bench for tft_text_renderer: two instances (ROWS=30 and ROWS=29) against a per-strobe
// pixel model, plus directed literal checks.
module tb_tft_text_renderer;

    localparam logic [23:0] FG = 24'hF0E0D0;
    localparam logic [23:0] BG = 24'h102030;
    localparam int          BF = 2;

    typedef struct packed {
        logic       hs, vs, de;
        logic [9:0] x, y;
        logic       cen;
        logic [6:0] ccol;
        logic [4:0] crow;
    } smp_t;

    localparam smp_t RST = {3'b110, 33'd0};

    logic        clk, reset, px_en;
    logic        hsync_i, vsync_i, de_i;
    logic [9:0]  x_i, y_i;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;

    logic [12:0] text_addr_a, text_addr_b;
    logic [31:0] text_data_a, text_data_b;
    logic [11:0] font_addr_a, font_addr_b;
    logic [7:0]  font_data_a, font_data_b;
    logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic        hsync_a, vsync_a, de_a, hsync_b, vsync_b, de_b;

    logic [7:0] tmem [8192];
    logic [7:0] fnt  [4096];

    int vectors = 0;
    int fails   = 0;

    tft_text_renderer #(
        .ROWS(30), .FG_RGB(FG), .BG_RGB(BG), .BLINK_FRAMES(BF)
    ) dut_a (
        .clk(clk), .reset(reset), .px_en(px_en),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .de_i(de_i), .x_i(x_i), .y_i(y_i),
        .text_addr(text_addr_a), .text_data(text_data_a),
        .font_addr(font_addr_a), .font_data(font_data_a),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .r(r_a), .g(g_a), .b(b_a), .hsync(hsync_a), .vsync(vsync_a), .de(de_a)
    );

    tft_text_renderer #(
        .ROWS(29), .FG_RGB(FG), .BG_RGB(BG), .BLINK_FRAMES(BF)
    ) dut_b (
        .clk(clk), .reset(reset), .px_en(px_en),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .de_i(de_i), .x_i(x_i), .y_i(y_i),
        .text_addr(text_addr_b), .text_data(text_data_b),
        .font_addr(font_addr_b), .font_data(font_data_b),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .r(r_b), .g(g_b), .b(b_b), .hsync(hsync_b), .vsync(vsync_b), .de(de_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memories with one clock of read latency
    always @(posedge clk) begin
        text_data_a <= {tmem[{text_addr_a[12:2], 2'd3}], tmem[{text_addr_a[12:2], 2'd2}],
                        tmem[{text_addr_a[12:2], 2'd1}], tmem[{text_addr_a[12:2], 2'd0}]};
        text_data_b <= {tmem[{text_addr_b[12:2], 2'd3}], tmem[{text_addr_b[12:2], 2'd2}],
                        tmem[{text_addr_b[12:2], 2'd1}], tmem[{text_addr_b[12:2], 2'd0}]};
        font_data_a <= fnt[font_addr_a];
        font_data_b <= fnt[font_addr_b];
    end

    // Colour of one sampled pixel, using the cursor seen one strobe later and the edge count.
    function automatic logic [23:0] pix(input smp_t s, input smp_t c, input int edges,
                                        input int rows);
        int         col, row;
        logic [7:0] ch, f;
        logic       bit_on, swap;
        if (!s.de) return 24'h0;
        col = int'(s.x) / 8;
        row = int'(s.y) / 16;
        if (col >= 100 || row >= rows) return BG;
        ch     = tmem[row * 100 + col];
        f      = fnt[{ch, s.y[3:0]}];
        bit_on = f[7 - (int'(s.x) % 8)];
        swap   = c.cen && col == int'(c.ccol) && row == int'(c.crow) && ((edges / BF) % 2 == 1);
        return (bit_on ^ swap) ? FG : BG;
    endfunction

    smp_t        p1, p2;
    logic        pvs;
    int          edges;
    logic [23:0] exp_a, exp_b;
    logic [2:0]  exp_ctl;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            p1      <= RST;
            p2      <= RST;
            pvs     <= 1'b1;
            edges   <= 0;
            exp_a   <= 24'h0;
            exp_b   <= 24'h0;
            exp_ctl <= 3'b110;
        end else if (px_en) begin
            exp_a   <= pix(p2, p1, edges, 30);
            exp_b   <= pix(p2, p1, edges, 29);
            exp_ctl <= {p2.hs, p2.vs, p2.de};
            p2      <= p1;
            p1      <= {hsync_i, vsync_i, de_i, x_i, y_i, cursor_en, cursor_col, cursor_row};
            if (pvs && !vsync_i) edges <= edges + 1;
            pvs     <= vsync_i;
        end
    end

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("rgb_a", {r_a, g_a, b_a}, exp_a);
        check("rgb_b", {r_b, g_b, b_b}, exp_b);
        check("ctl_a", {21'd0, hsync_a, vsync_a, de_a}, {21'd0, exp_ctl});
        check("ctl_b", {21'd0, hsync_b, vsync_b, de_b}, {21'd0, exp_ctl});
    end

    // Called at posedge+2; returns at posedge+2 with at least one idle clock after the strobe.
    task automatic strobe(input logic hs, input logic vs, input logic d, input int x, input int y,
                          input int gap, input bit rnd);
        hsync_i = hs;
        vsync_i = vs;
        de_i    = d;
        x_i     = 10'(x);
        y_i     = 10'(y);
        px_en   = 1'b1;
        @(posedge clk);
        #2;
        px_en = 1'b0;
        if (rnd) begin
            x_i  = 10'($urandom_range(0, 799));
            y_i  = 10'($urandom_range(0, 479));
            de_i = 1'($urandom_range(0, 1));
        end
        repeat (gap) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        for (int a = 0; a < 8192; a++) tmem[a] = 8'((a * 7 + 3) & 255);
        for (int i = 0; i < 4096; i++) fnt[i] = 8'((i * 13) ^ (i >> 3));
        tmem[0]     = 8'h41;
        fnt[12'h410] = 8'h81;

        reset      = 1'b1;
        px_en      = 1'b0;
        hsync_i    = 1'b1;
        vsync_i    = 1'b1;
        de_i       = 1'b0;
        x_i        = '0;
        y_i        = '0;
        cursor_en  = 1'b0;
        cursor_col = '0;
        cursor_row = '0;

        @(posedge clk);
        #2;
        check("reset_rgb", {r_a, g_a, b_a}, 24'h0);
        check("reset_ctl", {21'd0, hsync_a, vsync_a, de_a}, 24'h6);
        check("reset_text_addr", {11'd0, text_addr_a}, 24'h0);
        check("reset_font_addr", {12'd0, font_addr_a}, 24'h0);
        reset = 1'b0;
        @(posedge clk);
        #2;

        // Glyph 0x41 row 0 = 1000_0001 across x=0..7
        for (int i = 0; i < 10; i++) begin
            strobe(1'b1, 1'b1, i < 8, (i < 8) ? i : 0, 0, 1, 1'b0);
            if (i == 0) check("t2_text_addr", {11'd0, text_addr_a}, 24'd0);
            if (i == 1) check("t2_font_addr", {12'd0, font_addr_a}, 24'h410);
            if (i >= 2) check("t2_rgb", {r_a, g_a, b_a}, (i == 2 || i == 9) ? FG : BG);
        end

        // Last cell, byte lane 3, glyph row 15, then a blanked pixel
        strobe(1'b1, 1'b1, 1'b1, 799, 479, 1, 1'b0);
        check("t3_text_addr", {11'd0, text_addr_a}, 24'd2999);
        strobe(1'b0, 1'b1, 1'b0, 0, 0, 1, 1'b0);
        check("t3_font_addr", {12'd0, font_addr_a}, 24'h04F);
        strobe(1'b0, 1'b1, 1'b0, 0, 0, 1, 1'b0);
        strobe(1'b1, 1'b1, 1'b0, 0, 0, 1, 1'b0);
        check("t3_blank_rgb", {r_a, g_a, b_a}, 24'h0);

        // Row 29 is outside the ROWS=29 instance only
        strobe(1'b1, 1'b1, 1'b1, 10, 470, 1, 1'b0);
        check("t4_text_addr_b", {11'd0, text_addr_b}, 24'd0);
        check("t4_text_addr_a", {11'd0, text_addr_a}, 24'd2901);
        strobe(1'b1, 1'b1, 1'b0, 0, 0, 1, 1'b0);
        strobe(1'b1, 1'b1, 1'b0, 0, 0, 1, 1'b0);
        check("t4_oor_rgb_b", {r_b, g_b, b_b}, BG);

        // Reset in the middle of a visible line
        for (int i = 0; i < 3; i++) strobe(1'b1, 1'b1, 1'b1, 0, 0, 1, 1'b0);
        reset = 1'b1;
        #1;
        check("t1_rgb", {r_a, g_a, b_a}, 24'h0);
        check("t1_ctl", {21'd0, hsync_a, vsync_a, de_a}, 24'h6);
        check("t1_text_addr", {11'd0, text_addr_a}, 24'h0);
        check("t1_font_addr", {12'd0, font_addr_a}, 24'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            strobe(1'b1, 1'b1, 1'b1, 0, 0, 1, 1'b0);
            check("t1_refill_ctl", {21'd0, hsync_a, vsync_a, de_a}, (i < 2) ? 24'h6 : 24'h7);
        end
        check("t1_refill_rgb", {r_a, g_a, b_a}, FG);

        // Cursor at (5,2); pixel (40,32) has a clear font bit, so it reads BG unless inverted
        cursor_en  = 1'b1;
        cursor_col = 7'd5;
        cursor_row = 5'd2;
        for (int p = 0; p < 5; p++) begin
            strobe(1'b1, 1'b1, 1'b1, 40, 32, 1, 1'b0);
            for (int k = 0; k < 4; k++) strobe(1'b1, p > 0 ? 1'b0 : 1'b1, 1'b1, 40, 32, 1, 1'b0);
            check("t5_cursor_rgb", {r_a, g_a, b_a}, (p == 2 || p == 3) ? FG : BG);
        end

        // Two short frames of random pixels, px_en every 4 clocks
        for (int f = 0; f < 2; f++) begin
            cursor_col = (f == 0) ? 7'd5 : 7'd6;
            for (int i = 0; i < 300; i++) begin
                int x, y;
                if ($urandom_range(0, 3) == 0) begin
                    x = int'(cursor_col) * 8 + $urandom_range(0, 7);
                    y = 32 + $urandom_range(0, 15);
                end else begin
                    x = $urandom_range(0, 799);
                    y = $urandom_range(0, 479);
                end
                strobe((i % 50) >= 5, i >= 8, $urandom_range(0, 3) != 0, x, y, 3, 1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
